// File: rtl/spi_flash_rd_seq_if.sv
// Signal bundle for spi_flash_rd_seq: read request/status, SPI flash pins and
// the 1-bit FIFO write port. The sequencer uses the slave modport.
interface spi_flash_rd_seq_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [23:0]      addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             overflow;
  logic             cs_n;
  logic             sck;
  logic             mosi;
  logic             miso;
  logic             fifo_wr_en;
  logic             fifo_wr_data;
  logic             fifo_full;
  logic             fifo_almost_full;

  modport slave (
    input  start, addr, len, miso, fifo_full, fifo_almost_full,
    output busy, done, overflow, cs_n, sck, mosi, fifo_wr_en, fifo_wr_data
  );

  modport master (
    output start, addr, len, miso, fifo_full, fifo_almost_full,
    input  busy, done, overflow, cs_n, sck, mosi, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/spi_flash_rd_seq.sv
// SPI flash (mode 0) read sequencer: command, 24-bit address, optional dummy
// cycles, then len bytes streamed MSB-first into a 1-bit FIFO write port.
// Define FAST_READ_EN for command 0x0B with DUMMY_CYC dummy clocks; otherwise 0x03.
module spi_flash_rd_seq #(
  parameter int HALF      = 2,
  parameter int LEN_W     = 16,
  parameter int DUMMY_CYC = 8
) (
  input logic               wr_clk,
  input logic               rst_n,
  spi_flash_rd_seq_if.slave bus
);

`ifdef FAST_READ_EN
  localparam logic [7:0] RD_CMD  = 8'h0B;
  localparam int         N_DUMMY = DUMMY_CYC;
`else
  localparam logic [7:0] RD_CMD  = 8'h03;
  localparam int         N_DUMMY = 0;
`endif

  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CS_SETUP = 4'd1;
  localparam logic [3:0] S_CMD      = 4'd2;
  localparam logic [3:0] S_ADDR     = 4'd3;
  localparam logic [3:0] S_DUMMY    = 4'd4;
  localparam logic [3:0] S_DATA     = 4'd5;
  localparam logic [3:0] S_PAUSE    = 4'd6;
  localparam logic [3:0] S_CS_HOLD  = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  logic [3:0]       r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic [7:0]       r_bit_cnt;
  logic [LEN_W-1:0] r_byte_cnt;
  logic [31:0]      r_shift;
  logic             r_sck;
  logic             r_cs_n;
  logic             r_mosi;
  logic             r_busy;
  logic             r_done;
  logic             r_overflow;
  logic             r_wr_en;
  logic             r_wr_data;

  logic w_sck_phase;
  logic w_timed;
  logic w_div_wrap;
  logic w_rise;
  logic w_fall;

  assign w_sck_phase = (r_state == S_CMD) || (r_state == S_ADDR) ||
                       (r_state == S_DUMMY) || (r_state == S_DATA);
  // CS setup/hold reuse the half-period divider as their delay timer.
  assign w_timed     = w_sck_phase || (r_state == S_CS_SETUP) || (r_state == S_CS_HOLD);
  assign w_div_wrap  = (r_div_cnt == DIV_W'(HALF - 1));
  assign w_rise      = w_sck_phase && w_div_wrap && !r_sck;
  assign w_fall      = w_sck_phase && w_div_wrap && r_sck;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register sees pre-edge values, independent of statement order.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_sck      <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;

      // The FIFO drops a push while full; remember that it happened.
      if (r_wr_en && bus.fifo_full) r_overflow <= 1'b1;

      if (w_timed) r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
      else         r_div_cnt <= '0;

      if (w_sck_phase && w_div_wrap) r_sck <= ~r_sck;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_shift    <= {RD_CMD, bus.addr};
            r_byte_cnt <= bus.len;
            r_bit_cnt  <= '0;
            if (bus.len == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_CS_SETUP;
              r_cs_n  <= 1'b0;
              r_mosi  <= RD_CMD[7];
            end
          end
        end

        S_CS_SETUP: if (w_div_wrap) r_state <= S_CMD;

        S_CMD: begin
          if (w_fall) begin
            r_shift <= {r_shift[30:0], 1'b0};
            r_mosi  <= r_shift[30];
            if (r_bit_cnt == 8'd7) begin
              r_bit_cnt <= '0;
              r_state   <= S_ADDR;
            end else begin
              r_bit_cnt <= r_bit_cnt + 8'd1;
            end
          end
        end

        S_ADDR: begin
          if (w_fall) begin
            // After the last address bit the shifter is empty, so mosi drops to 0.
            r_shift <= {r_shift[30:0], 1'b0};
            r_mosi  <= r_shift[30];
            if (r_bit_cnt == 8'd23) begin
              r_bit_cnt <= '0;
              r_state   <= (N_DUMMY != 0) ? S_DUMMY : S_DATA;
            end else begin
              r_bit_cnt <= r_bit_cnt + 8'd1;
            end
          end
        end

        S_DUMMY: begin
          if (w_fall) begin
            if (r_bit_cnt == 8'(N_DUMMY - 1)) begin
              r_bit_cnt <= '0;
              r_state   <= S_DATA;
            end else begin
              r_bit_cnt <= r_bit_cnt + 8'd1;
            end
          end
        end

        S_DATA: begin
          if (w_rise) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= bus.miso;
          end
          if (w_fall) begin
            if (r_bit_cnt == 8'd7) begin
              r_bit_cnt  <= '0;
              r_byte_cnt <= r_byte_cnt - LEN_W'(1);
              if (r_byte_cnt == LEN_W'(1)) r_state <= S_CS_HOLD;
              else if (bus.fifo_almost_full) r_state <= S_PAUSE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 8'd1;
            end
          end
        end

        S_PAUSE: if (!bus.fifo_almost_full) r_state <= S_DATA;

        S_CS_HOLD: begin
          if (w_div_wrap) begin
            r_cs_n  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.overflow     = r_overflow;
  assign bus.cs_n         = r_cs_n;
  assign bus.sck          = r_sck;
  assign bus.mosi         = r_mosi;
  assign bus.fifo_wr_en   = r_wr_en;
  assign bus.fifo_wr_data = r_wr_data;

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Self-checking bench for spi_flash_rd_seq: behavioural flash model, pin
// monitor, and directed plus randomized read transactions.
module tb_spi_flash_rd_seq;

  localparam int HALF      = 2;
  localparam int LEN_W     = 16;
  localparam int DUMMY_CYC = 8;
`ifdef FAST_READ_EN
  localparam logic [7:0] EXP_CMD = 8'h0B;
  localparam int         N_DUMMY = DUMMY_CYC;
`else
  localparam logic [7:0] EXP_CMD = 8'h03;
  localparam int         N_DUMMY = 0;
`endif
  localparam int HDR      = 32 + N_DUMMY;
  localparam int WAIT_MAX = 5000;

  logic wr_clk = 1'b0;
  logic rst_n  = 1'b0;

  spi_flash_rd_seq_if #(.LEN_W(LEN_W)) sif ();

  spi_flash_rd_seq #(
    .HALF(HALF), .LEN_W(LEN_W), .DUMMY_CYC(DUMMY_CYC)
  ) dut (
    .wr_clk(wr_clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  always #5 wr_clk = ~wr_clk;

  // Flash model: counts SCK rises while selected; after the header it shifts
  // the stored bytes out MSB-first, changing MISO on each falling edge.
  logic [7:0] flash_data [16];
  int         fl_bits = 0;
  logic       miso_r  = 1'b0;
  assign sif.miso = miso_r;

  always @(posedge sif.sck or posedge sif.cs_n) begin
    if (sif.cs_n) fl_bits = 0;
    else          fl_bits = fl_bits + 1;
  end

  always @(negedge sif.sck) begin
    int k;
    k = fl_bits - HDR;
    if (!sif.cs_n && k >= 0 && k < 128) miso_r = flash_data[k / 8][7 - (k % 8)];
  end

  // Pin monitor, sampled on the inactive clock edge.
  int   rise_cnt     = 0;
  int   done_cnt     = 0;
  int   cs_low_cnt   = 0;
  int   busy_at_done = 0;
  logic prev_sck     = 1'b0;
  logic mosi_q [$];
  logic wr_q   [$];

  always @(negedge wr_clk) begin
    if (sif.sck === 1'b1 && prev_sck === 1'b0) begin
      rise_cnt++;
      mosi_q.push_back(sif.mosi);
    end
    prev_sck = sif.sck;
    if (sif.fifo_wr_en === 1'b1) wr_q.push_back(sif.fifo_wr_data);
    if (sif.done === 1'b1) begin
      done_cnt++;
      if (sif.busy !== 1'b0) busy_at_done++;
    end
    if (sif.cs_n === 1'b0) cs_low_cnt++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_random(input int l);
    for (int b = 0; b < l; b++) flash_data[b] = 8'($urandom);
  endtask

  // One complete read; every expectation comes from the protocol rules:
  // header = command then address, 8*len writes equal to the flash bytes.
  task automatic do_txn(input string tag, input logic [23:0] a, input int l);
    int          rb, wb, mb, db, cb, bb, n, exp_rises;
    logic [31:0] hdr_bits;
    logic        tail_or;
    logic [7:0]  byte_v;
    rb = rise_cnt; wb = wr_q.size(); mb = mosi_q.size();
    db = done_cnt; cb = cs_low_cnt;  bb = busy_at_done;
    exp_rises = (l == 0) ? 0 : HDR + 8 * l;

    @(negedge wr_clk);
    sif.start = 1'b1;
    sif.addr  = a;
    sif.len   = LEN_W'(l);
    @(negedge wr_clk);
    sif.start = 1'b0;
    sif.addr  = 24'($urandom);
    sif.len   = LEN_W'($urandom);
    check({tag, " busy_after_start"}, 32'(sif.busy), 32'd1);
    check({tag, " overflow_cleared"}, 32'(sif.overflow), 32'd0);

    n = 0;
    while (sif.done !== 1'b1 && n < WAIT_MAX) begin
      @(negedge wr_clk);
      n++;
    end
    check({tag, " done_seen"}, 32'(n < WAIT_MAX), 32'd1);
    check({tag, " busy_low_at_done"}, 32'(sif.busy), 32'd0);
    // With nothing to read, done follows two cycles after start was raised.
    if (l == 0) check({tag, " done_latency"}, 32'(n), 32'd1);

    repeat (3) @(negedge wr_clk);
    check({tag, " sck_rises"}, 32'(rise_cnt - rb), 32'(exp_rises));
    check({tag, " write_count"}, 32'(wr_q.size() - wb), 32'(8 * l));
    check({tag, " done_pulses"}, 32'(done_cnt - db), 32'd1);
    check({tag, " busy_with_done"}, 32'(busy_at_done - bb), 32'd0);
    check({tag, " idle_pins"}, 32'({sif.cs_n, sif.sck}), 32'b10);

    if (l == 0) begin
      check({tag, " cs_never_low"}, 32'(cs_low_cnt - cb), 32'd0);
    end else if (mosi_q.size() >= mb + exp_rises && wr_q.size() >= wb + 8 * l) begin
      hdr_bits = '0;
      for (int i = 0; i < 32; i++) hdr_bits = {hdr_bits[30:0], mosi_q[mb + i]};
      check({tag, " mosi_header"}, hdr_bits, {EXP_CMD, a});
      tail_or = 1'b0;
      for (int i = 32; i < exp_rises; i++) tail_or = tail_or | mosi_q[mb + i];
      check({tag, " mosi_zero_after_addr"}, 32'(tail_or), 32'd0);
      for (int b = 0; b < l; b++) begin
        byte_v = '0;
        for (int j = 0; j < 8; j++) byte_v = {byte_v[6:0], wr_q[wb + 8 * b + j]};
        check({tag, " data_byte"}, 32'(byte_v), 32'(flash_data[b]));
      end
    end
  endtask

  initial begin
    int   n, rb;
    logic pause_ok;

    sif.start            = 1'b0;
    sif.addr             = '0;
    sif.len              = '0;
    sif.fifo_full        = 1'b0;
    sif.fifo_almost_full = 1'b0;

    repeat (3) @(negedge wr_clk);
    check("reset_outputs",
          32'({sif.cs_n, sif.sck, sif.mosi, sif.busy, sif.done,
               sif.overflow, sif.fifo_wr_en, sif.fifo_wr_data}),
          32'b1000_0000);
    rst_n = 1'b1;
    @(negedge wr_clk);

    // Single byte 0xA5 at 0x123456: writes 1,0,1,0,0,1,0,1.
    flash_data[0] = 8'hA5;
    do_txn("single", 24'h123456, 1);

    do_txn("len0", 24'hABCDEF, 0);

    for (int t = 0; t < 4; t++) begin
      int l;
      l = $urandom_range(1, 3);
      load_random(l);
      do_txn("rand", 24'($urandom), l);
    end

    // Back-pressure after the first byte, held for 20 cycles.
    load_random(4);
    pause_ok = 1'b0;
    fork
      do_txn("backpressure", 24'($urandom), 4);
      begin
        int seen;
        seen = 0; n = 0;
        while (seen < 8 && n < WAIT_MAX) begin
          @(negedge wr_clk);
          n++;
          if (sif.fifo_wr_en === 1'b1) seen++;
        end
        sif.fifo_almost_full = 1'b1;
        n = 0;
        while (sif.sck !== 1'b0 && n < WAIT_MAX) begin
          @(negedge wr_clk);
          n++;
        end
        pause_ok = 1'b1;
        repeat (20) begin
          @(negedge wr_clk);
          if (sif.sck !== 1'b0 || sif.cs_n !== 1'b0) pause_ok = 1'b0;
        end
        sif.fifo_almost_full = 1'b0;
      end
    join
    check("pause_pins_held", 32'(pause_ok), 32'd1);

    // One write lands while the FIFO reports full.
    load_random(1);
    fork
      do_txn("overflow_txn", 24'($urandom), 1);
      begin
        n = 0;
        while (sif.fifo_wr_en !== 1'b1 && n < WAIT_MAX) begin
          @(negedge wr_clk);
          n++;
        end
        sif.fifo_full = 1'b1;
        @(negedge wr_clk);
        sif.fifo_full = 1'b0;
      end
    join
    check("overflow_sticky", 32'(sif.overflow), 32'd1);

    load_random(2);
    do_txn("after_overflow", 24'($urandom), 2);

    // Asynchronous reset in the middle of the address phase.
    load_random(2);
    rb = rise_cnt;
    @(negedge wr_clk);
    sif.start = 1'b1;
    sif.addr  = 24'h5A5A5A;
    sif.len   = LEN_W'(2);
    @(negedge wr_clk);
    sif.start = 1'b0;
    n = 0;
    while (rise_cnt < rb + 8 + 10 && n < WAIT_MAX) begin
      @(negedge wr_clk);
      n++;
    end
    check("reached_addr_bit10", 32'(n < WAIT_MAX), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("reset_mid_addr", 32'({sif.cs_n, sif.sck, sif.busy}), 32'b100);
    repeat (2) @(negedge wr_clk);
    rst_n = 1'b1;
    @(negedge wr_clk);

    // Normal read after reset; a second start while busy must be ignored.
    load_random(1);
    fork
      do_txn("post_reset", 24'($urandom), 1);
      begin
        repeat (12) @(negedge wr_clk);
        sif.start = 1'b1;
        @(negedge wr_clk);
        sif.start = 1'b0;
      end
    join
    repeat (10) @(negedge wr_clk);
    check("no_restart", 32'(sif.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
